// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the inter-stage pipeline buffer: controller control word
// encoding and the local occupancy state.
package pipe_stage_buf_pkg;

  localparam int CTRL_W = 2;

  localparam logic [CTRL_W-1:0] CTRL_DEFAULT = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_STALLED = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE  = 2'b10;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == CTRL_DEFAULT) || (ctrl == CTRL_STALLED) || (ctrl == CTRL_BUBBLE);
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones, clears on
// asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: 2-entry skid FIFO with valid/ready on both
// sides, controller-driven stall/bubble, and saturating perf counters.
//
// state     | meaning
// OCC_EMPTY | no entries held, out_data_o shows RESET_VALUE
// OCC_ONE   | one entry at head_q
// OCC_FULL  | two entries, head_q is oldest; upstream ready is low
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int               WIDTH         = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               BUBBLE_INSERT = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE  = '0,
  parameter int               CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic              ctrl_err_o
);

  occ_e             occ_q, occ_nxt;
  logic             head_q, head_nxt;
  logic             tail_q, tail_nxt;
  logic [WIDTH-1:0] entry_q [2];

  logic             wr_en;
  logic             wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             is_default, is_stall, is_flush;
  logic             push, pop;

  always_comb begin
    occ_nxt    = occ_q;
    head_nxt   = head_q;
    tail_nxt   = tail_q;
    wr_en      = 1'b0;
    wr_idx     = tail_q;
    wr_data    = in_data_i;
    is_default = (ctrl_signal_i == CTRL_DEFAULT);
    is_stall   = (ctrl_signal_i == CTRL_STALLED);
    // Illegal encodings fall into the flush path alongside Bubble.
    is_flush   = !is_default && !is_stall;
    in_ready_o  = is_default && (occ_q != OCC_FULL);
    out_valid_o = is_default && (occ_q != OCC_EMPTY);
    push = in_valid_i && in_ready_o;
    pop  = out_valid_o && out_ready_i;

    if (is_flush) begin
      head_nxt = 1'b0;
      if (BUBBLE_INSERT != 0) begin
        occ_nxt  = OCC_ONE;
        tail_nxt = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = 1'b0;
        wr_data  = BUBBLE_VALUE;
      end else begin
        occ_nxt  = OCC_EMPTY;
        tail_nxt = 1'b0;
      end
    end else if (is_default) begin
      if (push) begin
        wr_en    = 1'b1;
        tail_nxt = ~tail_q;
      end
      if (pop) begin
        head_nxt = ~head_q;
      end
      case (occ_q)
        OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_nxt = OCC_FULL;
          else if (!push && pop) occ_nxt = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
        default:   occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      occ_q  <= occ_nxt;
      head_q <= head_nxt;
      tail_q <= tail_nxt;
    end
  end

  // Payload registers need no reset: they are only visible when occupied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_err_o <= 1'b0;
    end else if (!ctrl_is_legal(ctrl_signal_i)) begin
      ctrl_err_o <= 1'b1;
    end
  end

  assign out_data_o = (occ_q != OCC_EMPTY) ? entry_q[head_q] : RESET_VALUE;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (is_stall),
    .cnt (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (is_flush),
    .cnt (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one instance with NOP injection and wide
// counters, one with flush-only bubbles and 2-bit counters, on shared stimulus.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hEE;
  localparam logic [W-1:0] BV = 8'h13;

  logic              clk = 1'b0;
  logic              rst;
  logic [CTRL_W-1:0] ctrl;
  logic              in_valid, out_ready;
  logic [W-1:0]      in_data;

  logic              in_ready_a, out_valid_a, err_a;
  logic [W-1:0]      out_data_a;
  logic [15:0]       stall_a, bubble_a;

  logic              in_ready_b, out_valid_b, err_b;
  logic [W-1:0]      out_data_b;
  logic [1:0]        stall_b, bubble_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .RESET_VALUE(RV), .BUBBLE_INSERT(1), .BUBBLE_VALUE(BV), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .stall_cnt_o(stall_a), .bubble_cnt_o(bubble_a), .ctrl_err_o(err_a)
  );

  pipe_stage_buf #(.WIDTH(W), .RESET_VALUE(RV), .BUBBLE_INSERT(0), .BUBBLE_VALUE(BV), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .ctrl_signal_i(ctrl),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .stall_cnt_o(stall_b), .bubble_cnt_o(bubble_b), .ctrl_err_o(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; ctrl = CTRL_DEFAULT; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'h0);
    chk("rst_data", 32'(out_data_a), 32'(RV));
    chk("rst_stall", 32'(stall_a), 32'h0);
    chk("rst_bubble", 32'(bubble_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_ready", 32'(in_ready_a), 32'h1);
    tick(2);
    rst = 1'b1;
    tick();

    // Streaming with downstream always ready
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    #1 chk("str_empty_valid", 32'(out_valid_a), 32'h0);
    tick();
    chk("str_out0", 32'(out_data_a), 32'h11);
    chk("str_valid0", 32'(out_valid_a), 32'h1);
    in_data = 8'h22;
    tick();
    chk("str_out1", 32'(out_data_a), 32'h22);
    chk("str_ready1", 32'(in_ready_a), 32'h1);
    in_data = 8'h33;
    tick();
    chk("str_out2", 32'(out_data_a), 32'h33);
    in_valid = 1'b0;
    tick();
    chk("str_drain_valid", 32'(out_valid_a), 32'h0);
    chk("str_drain_data", 32'(out_data_a), 32'(RV));

    // Backpressure fills both entries
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    tick();
    in_data = 8'h0B;
    #1 chk("bp_ready_one", 32'(in_ready_a), 32'h1);
    tick();
    chk("bp_ready_full", 32'(in_ready_a), 32'h0);
    chk("bp_head_full", 32'(out_data_a), 32'h0A);
    in_data = 8'h0C;
    tick();
    chk("bp_held_head", 32'(out_data_a), 32'h0A);

    // Stall while full
    ctrl = CTRL_STALLED;
    #1;
    chk("stl_ready", 32'(in_ready_a), 32'h0);
    chk("stl_valid", 32'(out_valid_a), 32'h0);
    tick(5);
    chk("stl_cnt5", 32'(stall_a), 32'd5);
    chk("stl_cnt_sat", 32'(stall_b), 32'd3);
    chk("stl_kept", 32'(out_data_a), 32'h0A);
    tick();
    chk("stl_cnt6", 32'(stall_a), 32'd6);
    chk("stl_sat_held", 32'(stall_b), 32'd3);

    // Resume and drain A, B, then C
    ctrl = CTRL_DEFAULT; out_ready = 1'b1;
    #1 chk("rsm_head_a", 32'(out_data_a), 32'h0A);
    tick();
    chk("rsm_head_b", 32'(out_data_a), 32'h0B);
    tick();
    chk("rsm_head_c", 32'(out_data_a), 32'h0C);
    chk("rsm_stall_hold", 32'(stall_a), 32'd6);
    in_valid = 1'b0;
    tick();
    chk("rsm_empty", 32'(out_valid_a), 32'h0);

    // Bubble on a full buffer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_data = 8'h55;
    tick();
    in_valid = 1'b0; ctrl = CTRL_BUBBLE;
    tick();
    ctrl = CTRL_DEFAULT;
    #1;
    chk("bub_valid_ins", 32'(out_valid_a), 32'h1);
    chk("bub_data_ins", 32'(out_data_a), 32'(BV));
    chk("bub_cnt", 32'(bubble_a), 32'd1);
    chk("bub_valid_flush", 32'(out_valid_b), 32'h0);
    chk("bub_data_flush", 32'(out_data_b), 32'(RV));
    chk("bub_cnt_b", 32'(bubble_b), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bub_nop_popped", 32'(out_valid_a), 32'h0);

    // Consecutive bubbles each count and reload
    out_ready = 1'b0; ctrl = CTRL_BUBBLE;
    tick(3);
    ctrl = CTRL_DEFAULT;
    #1;
    chk("bub3_cnt", 32'(bubble_a), 32'd4);
    chk("bub3_cnt_sat", 32'(bubble_b), 32'd3);
    chk("bub3_data", 32'(out_data_a), 32'(BV));
    chk("bub3_no_err", 32'(err_a), 32'h0);

    // Illegal control code flushes like Bubble and latches the error flag
    in_valid = 1'b1; in_data = 8'h66;
    tick();
    chk("ill_pre_full", 32'(in_ready_a), 32'h0);
    chk("ill_pre_b", 32'(out_data_b), 32'h66);
    in_valid = 1'b0; ctrl = 2'b11;
    #1 chk("ill_valid_low", 32'(out_valid_a), 32'h0);
    tick();
    ctrl = CTRL_DEFAULT;
    #1;
    chk("ill_err_a", 32'(err_a), 32'h1);
    chk("ill_err_b", 32'(err_b), 32'h1);
    chk("ill_flush_a", 32'(out_data_a), 32'(BV));
    chk("ill_ready_a", 32'(in_ready_a), 32'h1);
    chk("ill_flush_b", 32'(out_valid_b), 32'h0);
    chk("ill_bub_cnt", 32'(bubble_a), 32'd5);
    tick(3);
    chk("ill_sticky", 32'(err_a), 32'h1);

    // Asynchronous reset mid-traffic
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("mid_full", 32'(in_ready_a), 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid_a), 32'h0);
    chk("mid_data", 32'(out_data_a), 32'(RV));
    chk("mid_stall", 32'(stall_a), 32'h0);
    chk("mid_bubble", 32'(bubble_a), 32'h0);
    chk("mid_err", 32'(err_a), 32'h0);
    tick();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_ready", 32'(in_ready_a), 32'h1);
    chk("post_valid", 32'(out_valid_a), 32'h0);
    chk("post_data_b", 32'(out_data_b), 32'(RV));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
